// File: rtl/cla_sub32_pipe_pkg.sv
// Shared definitions for the pipelined CLA subtract/compare unit.
// Defaults, the result flag bundle and the per-stage chunk width helper.
package sub_pkg;

  localparam int SUB_WIDTH_DEF  = 32;
  localparam int SUB_STAGES_DEF = 2;

  typedef struct packed {
    logic bout;
    logic of;
    logic zero;
    logic lt;
    logic ltu;
  } sub_flags_t;

  function automatic int chunk_bits(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/cla_sub32_pipe_if.sv
// Operand/result stream bundle for cla_sub32_pipe.
// The slave side is the unit itself; the master side is the producer/consumer.
interface cla_sub32_pipe_if
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_bout;
  logic             out_of;
  logic             out_zero;
  logic             out_lt;
  logic             out_ltu;

  modport slave (
    input  in_valid, in_a, in_b, in_bin, out_ready,
    output in_ready, out_valid, out_diff, out_bout, out_of, out_zero, out_lt, out_ltu
  );

  modport master (
    output in_valid, in_a, in_b, in_bin, out_ready,
    input  in_ready, out_valid, out_diff, out_bout, out_of, out_zero, out_lt, out_ltu
  );
endinterface

// File: rtl/cla_chunk_sub.sv
// Combinational CHUNK-bit a + ~b + cin built from 4-bit CLA groups.
// Group carries ripple from one group to the next.
module cla_chunk_sub
  import sub_pkg::*;
#(
  parameter int CHUNK = chunk_bits(SUB_WIDTH_DEF, SUB_STAGES_DEF)
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] diff,
  output logic             cout
);
  localparam int NG = CHUNK / 4;

  logic [CHUNK-1:0] bn;
  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] c;
  logic [NG:0]      gc;

  assign bn    = ~b;
  assign p     = a ^ bn;
  assign g     = a & bn;
  assign gc[0] = cin;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    localparam int L = gi * 4;
    logic grp_g;
    logic grp_p;

    assign c[L]   = gc[gi];
    assign c[L+1] = g[L] | (p[L] & gc[gi]);
    assign c[L+2] = g[L+1] | (p[L+1] & g[L]) | (p[L+1] & p[L] & gc[gi]);
    assign c[L+3] = g[L+2] | (p[L+2] & g[L+1]) | (p[L+2] & p[L+1] & g[L])
                  | (p[L+2] & p[L+1] & p[L] & gc[gi]);

    // Group generate/propagate let the next group's carry skip the inner bits.
    assign grp_g = g[L+3] | (p[L+3] & g[L+2]) | (p[L+3] & p[L+2] & g[L+1])
                 | (p[L+3] & p[L+2] & p[L+1] & g[L]);
    assign grp_p = &p[L+3:L];
    assign gc[gi+1] = grp_g | (grp_p & gc[gi]);
  end

  assign diff = p ^ c;
  assign cout = gc[NG];
endmodule

// File: rtl/cla_sub32_pipe.sv
// Pipelined subtract/compare unit: diff = a - b - bin, one CHUNK per stage.
// Each stage registers its carry and the untouched operand bits for the next.
module cla_sub32_pipe
  import sub_pkg::*;
#(
  parameter int WIDTH  = SUB_WIDTH_DEF,
  parameter int STAGES = SUB_STAGES_DEF
) (
  input logic             clk,
  input logic             rst,
  cla_sub32_pipe_if.slave bus
);
  localparam int CHUNK = chunk_bits(WIDTH, STAGES);
  localparam int MSB   = WIDTH - 1;

  // Index k of the *_in arrays is what stage k consumes.
  logic [WIDTH-1:0]  a_in    [STAGES];
  logic [WIDTH-1:0]  b_in    [STAGES];
  logic [WIDTH-1:0]  diff_in [STAGES];
  logic [STAGES-1:0] carry_in;
  logic [STAGES-1:0] valid_in;
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;

  assign a_in[0]     = bus.in_a;
  assign b_in[0]     = bus.in_b;
  assign diff_in[0]  = '0;
  assign carry_in[0] = ~bus.in_bin;
  assign valid_in[0] = bus.in_valid;
  assign bus.in_ready = load[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [CHUNK-1:0] chunk_diff;
    logic             chunk_cout;
    logic [WIDTH-1:0] diff_new;
    logic             valid_reg;

    cla_chunk_sub #(.CHUNK(CHUNK)) u_chunk (
      .a    (a_in[gi][gi*CHUNK +: CHUNK]),
      .b    (b_in[gi][gi*CHUNK +: CHUNK]),
      .cin  (carry_in[gi]),
      .diff (chunk_diff),
      .cout (chunk_cout)
    );

    assign diff_new  = diff_in[gi] | (WIDTH'(chunk_diff) << (gi * CHUNK));
    assign valid[gi] = valid_reg;
    assign load[gi]  = ~valid[gi] | adv[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
      end else if (load[gi]) begin
        valid_reg <= valid_in[gi];
      end
    end

    if (gi == STAGES - 1) begin : g_last
      logic [WIDTH-1:0] diff_reg;
      sub_flags_t       flags_reg;
      sub_flags_t       flags_next;

      assign adv[gi] = bus.out_ready;

      always_comb begin
        flags_next      = '0;
        flags_next.bout = ~chunk_cout;
        flags_next.of   = (a_in[gi][MSB] != b_in[gi][MSB]) && (diff_new[MSB] != a_in[gi][MSB]);
        flags_next.lt   = diff_new[MSB] ^ flags_next.of;
        flags_next.zero = (diff_new == '0);
        flags_next.ltu  = flags_next.bout;
      end

      // Only the output stage is cleared so the result port reads zero after reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          diff_reg  <= '0;
          flags_reg <= '0;
        end else if (load[gi] && valid_in[gi]) begin
          diff_reg  <= diff_new;
          flags_reg <= flags_next;
        end
      end

      assign bus.out_valid = valid_reg;
      assign bus.out_diff  = diff_reg;
      assign bus.out_bout  = flags_reg.bout;
      assign bus.out_of    = flags_reg.of;
      assign bus.out_zero  = flags_reg.zero;
      assign bus.out_lt    = flags_reg.lt;
      assign bus.out_ltu   = flags_reg.ltu;
    end else begin : g_mid
      logic [WIDTH-1:0] a_reg;
      logic [WIDTH-1:0] b_reg;
      logic [WIDTH-1:0] diff_reg;
      logic             carry_reg;

      assign adv[gi] = ~valid[gi+1] | adv[gi+1];

      always_ff @(posedge clk) begin
        if (load[gi] && valid_in[gi]) begin
          a_reg     <= a_in[gi];
          b_reg     <= b_in[gi];
          diff_reg  <= diff_new;
          carry_reg <= chunk_cout;
        end
      end

      assign a_in[gi+1]     = a_reg;
      assign b_in[gi+1]     = b_reg;
      assign diff_in[gi+1]  = diff_reg;
      assign carry_in[gi+1] = carry_reg;
      assign valid_in[gi+1] = valid_reg;
    end
  end
endmodule

// File: tb/tb_cla_sub32_pipe.sv
// Directed vector table, stall/full-rate streams, mid-flight reset and a random soak
// for cla_sub32_pipe, each checked against hand values or an arithmetic model.
module tb_cla_sub32_pipe;
  import sub_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cla_sub32_pipe_if #(.WIDTH(W)) bus ();

  cla_sub32_pipe #(.WIDTH(W), .STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // fl = {bout, of, zero, lt, ltu}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] diff;
    logic [4:0]  fl;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] act_flags();
    return {bus.out_bout, bus.out_of, bus.out_zero, bus.out_lt, bus.out_ltu};
  endfunction

  // Reference from wide arithmetic: unsigned borrow and true signed result.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    vec_t r;
    logic [32:0]        u;
    logic signed [33:0] s;
    logic               of;
    u  = {1'b0, a} - {1'b0, b} - {32'b0, bin};
    s  = $signed({{2{a[31]}}, a}) - $signed({{2{b[31]}}, b}) - $signed({33'b0, bin});
    of = (s[33:31] != {3{s[31]}});
    r.a    = a;
    r.b    = b;
    r.bin  = bin;
    r.diff = u[31:0];
    r.fl   = {u[32], of, (u[31:0] == 32'd0), s[33], u[32]};
    return r;
  endfunction

  task automatic apply_vec(input string tag, input vec_t v);
    int lat;
    bus.in_a      = v.a;
    bus.in_b      = v.b;
    bus.in_bin    = v.bin;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #2;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd2);
    chk({tag, ".diff"}, bus.out_diff, v.diff);
    chk({tag, ".flags"}, 32'(act_flags()), 32'(v.fl));
    $display("%s a=%h b=%h bin=%0d -> diff=%h flags=%b lat=%0d", tag, v.a, v.b, v.bin,
             bus.out_diff, act_flags(), lat);
    @(posedge clk); #1;
    chk({tag, ".drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  // mode 0: stall out_ready on cycles 2..5; mode 1: random; mode 2: full rate.
  task automatic run_stream(input string tag, input int nbeats, input int mode,
                            input int max_cycles, output int cycles);
    vec_t        exp_q [$];
    vec_t        e;
    int          sent = 0;
    int          got  = 0;
    int          cyc  = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] held_diff  = '0;
    logic [4:0]  held_fl    = '0;
    logic        acc;
    logic        drn;
    bus.in_valid = 1'b0;
    while (got < nbeats && cyc < max_cycles) begin
      case (mode)
        0:       bus.out_ready = !(cyc >= 2 && cyc <= 5);
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b1;
      endcase
      if (!bus.in_valid && sent < nbeats && (mode != 1 || $urandom_range(0, 3) != 0)) begin
        if (mode == 1) begin
          bus.in_a   = $urandom;
          bus.in_b   = ($urandom_range(0, 3) == 0) ? bus.in_a : $urandom;
          bus.in_bin = 1'($urandom_range(0, 1));
        end else begin
          bus.in_a   = 32'(sent * 1000 + 50);
          bus.in_b   = 32'(sent * 3000 + 7);
          bus.in_bin = 1'(sent % 2);
        end
        bus.in_valid = 1'b1;
      end
      #2;
      if (mode == 0)
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(!(cyc >= 2 && cyc <= 5)));
      else if (mode == 2)
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
      if (stall_prev) begin
        chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".hold_diff"}, bus.out_diff, held_diff);
        chk({tag, ".hold_flags"}, 32'(act_flags()), 32'(held_fl));
      end
      acc = bus.in_valid && bus.in_ready;
      drn = bus.out_valid && bus.out_ready;
      if (drn) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s.extra_beat: got diff %h want no beat", tag, bus.out_diff);
        end else begin
          e = exp_q.pop_front();
          chk({tag, ".diff"}, bus.out_diff, e.diff);
          chk({tag, ".flags"}, 32'(act_flags()), 32'(e.fl));
          $display("%s beat %0d a=%h b=%h bin=%0d -> diff=%h flags=%b", tag, got, e.a, e.b,
                   e.bin, bus.out_diff, act_flags());
          got++;
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held_diff  = bus.out_diff;
      held_fl    = act_flags();
      if (acc) begin
        exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_bin));
        sent++;
      end
      @(posedge clk); #1;
      if (acc) bus.in_valid = 1'b0;
      cyc++;
    end
    chk({tag, ".count"}, 32'(got), 32'(nbeats));
    chk({tag, ".leftover"}, 32'(exp_q.size()), 32'd0);
    chk({tag, ".idle"}, 32'(bus.out_valid), 32'd0);
    cycles = cyc;
  endtask

  initial begin
    int   cycles;
    vec_t v;
    vecs[0]  = '{32'd5,        32'd3,        1'b0, 32'h00000002, 5'b00000};
    vecs[1]  = '{32'd0,        32'd1,        1'b0, 32'hFFFFFFFF, 5'b10011};
    vecs[2]  = '{32'h80000000, 32'd1,        1'b0, 32'h7FFFFFFF, 5'b01010};
    vecs[3]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 5'b11001};
    vecs[4]  = '{32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 5'b00100};
    vecs[5]  = '{32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 5'b10011};
    vecs[6]  = '{32'd0,        32'd0,        1'b1, 32'hFFFFFFFF, 5'b10011};
    vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 5'b00100};
    vecs[8]  = '{32'h0000FFFF, 32'h00010000, 1'b0, 32'hFFFFFFFF, 5'b10011};
    vecs[9]  = '{32'h00010000, 32'd1,        1'b0, 32'h0000FFFF, 5'b00000};
    vecs[10] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h00000001, 5'b01010};
    vecs[11] = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 32'hFFFFFFFF, 5'b11001};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_bin    = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset.diff", bus.out_diff, 32'd0);
    chk("reset.flags", 32'(act_flags()), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

    run_stream("stall", 6, 0, 60, cycles);
    run_stream("fullrate", 20, 2, 60, cycles);
    chk("fullrate.cycles", 32'(cycles), 32'd22);

    // Two beats in flight, then a one-cycle reset must discard both.
    bus.out_ready = 1'b0;
    bus.in_a = 32'd100; bus.in_b = 32'd1; bus.in_bin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_a = 32'd200; bus.in_b = 32'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst.diff", bus.out_diff, 32'd0);
    chk("midrst.flags", 32'(act_flags()), 32'd0);
    v = '{32'd9, 32'd4, 1'b0, 32'd5, 5'b00000};
    apply_vec("postrst", v);

    run_stream("soak", 10000, 1, 80000, cycles);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
